// File: rtl/dft12_stream_if.sv
// Handshake bundle for the 12-point streaming DFT: sample input port, bin output port and status.
interface dft12_stream_if #(
  parameter int DW = 16,
  parameter int OW = DW + 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 inverse;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [3:0]           out_index;
  logic                 out_last;
  logic                 out_sat;
  logic                 busy;

  modport slave (
    input  in_valid, in_re, in_im, inverse, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last, out_sat, busy
  );

  modport master (
    output in_valid, in_re, in_im, inverse, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last, out_sat, busy
  );
endinterface

// File: rtl/dft12_stream.sv
// Sequential 12-point DFT: buffers a frame, computes each bin with a 12-step complex MAC
// against a constant twiddle ROM, then rounds, saturates and streams bins 0..11.
module dft12_stream #(
  parameter int DW        = 16,
  parameter int CW        = 14,
  parameter int OW        = DW + 4,
  parameter int OUT_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dft12_stream_if.slave bus
);
  localparam int AW = DW + CW + 6;
  localparam int TW = CW + 2;
  localparam int SH = CW + OUT_SHIFT;

  function automatic longint isqrt_round(input longint x);
    longint r;
    longint t;
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    // round to nearest: bump when (r + 0.5)^2 <= x
    if (r * r + r < x) r = r + 1;
    return r;
  endfunction

  localparam longint ONE_L  = longint'(1) << CW;
  localparam longint HALF_L = longint'(1) << (CW - 1);
  localparam longint RT3_L  = isqrt_round(longint'(3) << (2 * CW - 2));

  localparam logic signed [TW-1:0] T_ONE  = TW'(ONE_L);
  localparam logic signed [TW-1:0] T_HALF = TW'(HALF_L);
  localparam logic signed [TW-1:0] T_RT3  = TW'(RT3_L);

  localparam logic signed [AW:0] RND  = (AW + 1)'(longint'(1) << (SH - 1));
  localparam logic signed [AW:0] MAXV = (AW + 1)'((longint'(1) << (OW - 1)) - 1);
  localparam logic signed [AW:0] MINV = -((AW + 1)'(longint'(1) << (OW - 1)));

  // LOAD: fill buffer | COMPUTE: 12-step MAC for bin k | ROUND: scale+clip | OUTPUT: hold bin until taken
  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_ROUND, S_OUTPUT} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [3:0]           r_k;
  logic [3:0]           r_n;
  logic [3:0]           r_m;
  logic                 r_inv;
  logic signed [AW-1:0] r_acc_re;
  logic signed [AW-1:0] r_acc_im;
  logic signed [DW-1:0] r_buf_re [12];
  logic signed [DW-1:0] r_buf_im [12];

  logic                 r_out_valid;
  logic signed [OW-1:0] r_out_re;
  logic signed [OW-1:0] r_out_im;
  logic [3:0]           r_out_index;
  logic                 r_out_last;
  logic                 r_out_sat;

  logic signed [DW-1:0] w_xr;
  logic signed [DW-1:0] w_xi;
  logic signed [TW-1:0] w_c;
  logic signed [TW-1:0] w_s;
  logic signed [TW-1:0] w_s_dir;
  logic signed [AW-1:0] w_xr_e;
  logic signed [AW-1:0] w_xi_e;
  logic signed [AW-1:0] w_c_e;
  logic signed [AW-1:0] w_s_e;
  logic signed [AW-1:0] w_term_re;
  logic signed [AW-1:0] w_term_im;
  logic [4:0]           w_msum;
  logic [3:0]           w_m_nxt;
  logic signed [AW:0]   w_rnd_re;
  logic signed [AW:0]   w_rnd_im;
  logic signed [AW:0]   w_shr_re;
  logic signed [AW:0]   w_shr_im;
  logic [OW:0]          w_sat_re;
  logic [OW:0]          w_sat_im;

  // Angle 30*m degrees: c = cos, s = sin, both scaled by 2^CW.
  always_comb begin
    w_c = T_ONE;
    w_s = '0;
    case (r_m)
      4'd1:    begin w_c =  T_RT3;  w_s =  T_HALF; end
      4'd2:    begin w_c =  T_HALF; w_s =  T_RT3;  end
      4'd3:    begin w_c =  '0;     w_s =  T_ONE;  end
      4'd4:    begin w_c = -T_HALF; w_s =  T_RT3;  end
      4'd5:    begin w_c = -T_RT3;  w_s =  T_HALF; end
      4'd6:    begin w_c = -T_ONE;  w_s =  '0;     end
      4'd7:    begin w_c = -T_RT3;  w_s = -T_HALF; end
      4'd8:    begin w_c = -T_HALF; w_s = -T_RT3;  end
      4'd9:    begin w_c =  '0;     w_s = -T_ONE;  end
      4'd10:   begin w_c =  T_HALF; w_s = -T_RT3;  end
      4'd11:   begin w_c =  T_RT3;  w_s = -T_HALF; end
      default: begin w_c =  T_ONE;  w_s =  '0;     end
    endcase
  end

  assign w_xr    = r_buf_re[r_n];
  assign w_xi    = r_buf_im[r_n];
  assign w_s_dir = r_inv ? -w_s : w_s;

  assign w_xr_e = AW'(w_xr);
  assign w_xi_e = AW'(w_xi);
  assign w_c_e  = AW'(w_c);
  assign w_s_e  = AW'(w_s_dir);

  assign w_term_re = w_xr_e * w_c_e + w_xi_e * w_s_e;
  assign w_term_im = w_xi_e * w_c_e - w_xr_e * w_s_e;

  // Twiddle index m = k*n mod 12, tracked incrementally.
  assign w_msum  = {1'b0, r_m} + {1'b0, r_k};
  assign w_m_nxt = (w_msum >= 5'd12) ? 4'(w_msum - 5'd12) : w_msum[3:0];

  assign w_rnd_re = (AW + 1)'(r_acc_re) + RND;
  assign w_rnd_im = (AW + 1)'(r_acc_im) + RND;
  assign w_shr_re = w_rnd_re >>> SH;
  assign w_shr_im = w_rnd_im >>> SH;

  function automatic logic [OW:0] clip(input logic signed [AW:0] v);
    if (v > MAXV)      return {1'b1, MAXV[OW-1:0]};
    else if (v < MINV) return {1'b1, MINV[OW-1:0]};
    else               return {1'b0, v[OW-1:0]};
  endfunction

  assign w_sat_re = clip(w_shr_re);
  assign w_sat_im = clip(w_shr_im);

  // Frame storage needs no reset; a partial frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && bus.in_valid) begin
      r_buf_re[r_cnt] <= bus.in_re;
      r_buf_im[r_cnt] <= bus.in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_k         <= '0;
      r_n         <= '0;
      r_m         <= '0;
      r_inv       <= 1'b0;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            if (r_cnt == 4'd0) r_inv <= bus.inverse;
            if (r_cnt == 4'd11) begin
              r_cnt    <= '0;
              r_k      <= '0;
              r_n      <= '0;
              r_m      <= '0;
              r_acc_re <= '0;
              r_acc_im <= '0;
              r_state  <= S_COMPUTE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_COMPUTE: begin
          r_acc_re <= r_acc_re + w_term_re;
          r_acc_im <= r_acc_im + w_term_im;
          r_m      <= w_m_nxt;
          r_n      <= r_n + 4'd1;
          if (r_n == 4'd11) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_out_re    <= w_sat_re[OW-1:0];
          r_out_im    <= w_sat_im[OW-1:0];
          r_out_sat   <= w_sat_re[OW] | w_sat_im[OW];
          r_out_index <= r_k;
          r_out_last  <= (r_k == 4'd11);
          r_out_valid <= 1'b1;
          r_state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_k != 4'd11) begin
              r_k      <= r_k + 4'd1;
              r_n      <= '0;
              r_m      <= '0;
              r_acc_re <= '0;
              r_acc_im <= '0;
              r_state  <= S_COMPUTE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.busy      = (r_state != S_LOAD) || (r_cnt != 4'd0);
  assign bus.out_valid = r_out_valid;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
  assign bus.out_index = r_out_index;
  assign bus.out_last  = r_out_last;
  assign bus.out_sat   = r_out_sat;
endmodule
